// File: rtl/sd_bd_pkg.sv
// Shared constants and types for the SD buffer-descriptor queue.
// A descriptor is two words: system address followed by command argument.
package sd_bd_pkg;
    localparam int DW       = 32;
    localparam int BD_DEPTH = 4;
    localparam int BD_W     = $clog2(BD_DEPTH) + 1;
    localparam int WORDS    = 2 * BD_DEPTH;
    localparam int IDX_W    = $clog2(WORDS);
    localparam int PTR_W    = IDX_W + 1;

    localparam logic            W_SYS_ADR = 1'b0;
    localparam logic            W_CMD_ARG = 1'b1;
    localparam logic [BD_W-1:0] BD_EMPTY  = BD_W'(BD_DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [DW-1:0]    word_t;

    // Storage index drops the wrap bit; wrap at 2*BD_DEPTH is implicit.
    function automatic idx_t ptr_idx(input ptr_t p);
        return p[IDX_W-1:0];
    endfunction
endpackage

// File: rtl/sd_bd_queue_if.sv
// Host-write / data-master-read bundle for one descriptor queue.
interface sd_bd_queue_if;
    import sd_bd_pkg::*;

    logic            we_m;
    word_t           dat_in_m;
    logic            new_bw;
    logic            wr_err;
    logic [BD_W-1:0] free_bd;
    logic            re_s;
    logic            ack_o_s;
    word_t           dat_out_s;
    logic            a_cmp;

    modport slave (
        input  we_m, dat_in_m, re_s, a_cmp,
        output new_bw, wr_err, free_bd, ack_o_s, dat_out_s
    );

    modport master (
        output we_m, dat_in_m, re_s, a_cmp,
        input  new_bw, wr_err, free_bd, ack_o_s, dat_out_s
    );
endinterface

// File: rtl/sd_bd_ram.sv
// Simple dual-port descriptor storage: synchronous write, registered read.
// The read register holds its value between reads and clears on reset/flush.
module sd_bd_ram
    import sd_bd_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  we_i,
    input  idx_t  waddr_i,
    input  word_t wdata_i,
    input  logic  re_i,
    input  idx_t  raddr_i,
    output word_t rdata_o
);
    word_t mem_q [WORDS];
    word_t rdata_q;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            rdata_q <= {DW{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sd_bd_queue.sv
// Buffer-descriptor queue between the host and the SD data master.
// Only fully written descriptors become readable; slots return on a_cmp.
module sd_bd_queue
    import sd_bd_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    sd_bd_queue_if.slave  bd
);
    ptr_t            wr_ptr_q, wr_ptr_d;
    ptr_t            cm_ptr_q, cm_ptr_d;
    ptr_t            rd_ptr_q, rd_ptr_d;
    logic [BD_W-1:0] free_bd_q, free_bd_d;
    logic            new_bw_q, new_bw_d;
    logic            wr_err_q, wr_err_d;
    logic            ack_q, ack_d;

    logic            wr_go_s;
    logic            commit_s;
    logic            rel_s;
    logic            rd_go_s;
    logic            full_s;
    word_t           rdata_s;

    // Handshake decode and next-state computation.
    always_comb begin
        full_s   = (free_bd_q == {BD_W{1'b0}});
        wr_go_s  = bd.we_m && !full_s;
        commit_s = wr_go_s && (wr_ptr_q[0] == W_CMD_ARG);
        rel_s    = bd.a_cmp && (free_bd_q != BD_EMPTY);
        // Blocking on ack_q enforces the idle cycle between acks.
        rd_go_s  = bd.re_s && (rd_ptr_q != cm_ptr_q) && !ack_q;

        wr_ptr_d  = wr_ptr_q;
        cm_ptr_d  = cm_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        free_bd_d = free_bd_q;
        new_bw_d  = commit_s;
        wr_err_d  = wr_err_q | (bd.we_m && full_s);
        ack_d     = rd_go_s;

        if (wr_go_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (commit_s) begin
            cm_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            cm_ptr_d = cm_ptr_q;
        end

        if (rd_go_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({commit_s, rel_s})
            2'b10:   free_bd_d = free_bd_q - BD_W'(1);
            2'b01:   free_bd_d = free_bd_q + BD_W'(1);
            default: free_bd_d = free_bd_q;
        endcase
    end

    // Control state registers; flush takes priority over every same-cycle event.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wr_ptr_q  <= {PTR_W{1'b0}};
            cm_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            free_bd_q <= BD_EMPTY;
            new_bw_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            cm_ptr_q  <= cm_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            free_bd_q <= free_bd_d;
            new_bw_q  <= new_bw_d;
            wr_err_q  <= wr_err_d;
            ack_q     <= ack_d;
        end
    end

    sd_bd_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .we_i    (wr_go_s),
        .waddr_i (ptr_idx(wr_ptr_q)),
        .wdata_i (bd.dat_in_m),
        .re_i    (rd_go_s),
        .raddr_i (ptr_idx(rd_ptr_q)),
        .rdata_o (rdata_s)
    );

    assign bd.new_bw    = new_bw_q;
    assign bd.wr_err    = wr_err_q;
    assign bd.free_bd   = free_bd_q;
    assign bd.ack_o_s   = ack_q;
    assign bd.dat_out_s = rdata_s;
endmodule

// File: tb/tb_sd_bd_queue.sv
// Directed self-checking bench for sd_bd_queue.
module tb_sd_bd_queue;
    logic clk;
    logic rst;
    logic clr;
    int   checks;
    int   failures;

    sd_bd_queue_if bif();

    sd_bd_queue dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bd  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [31:0] d);
        bif.we_m = 1'b1;
        bif.dat_in_m = d;
        tick();
        bif.we_m = 1'b0;
    endtask

    task automatic pulse_cmp();
        bif.a_cmp = 1'b1;
        tick();
        bif.a_cmp = 1'b0;
    endtask

    // Holds re_s until n acks or the cycle budget runs out, then counts stray acks.
    task automatic read_n(input int n, input int max_cyc, output int nack,
                          output bit consec, output logic [31:0] got [8]);
        bit prev;
        nack = 0;
        consec = 1'b0;
        prev = 1'b0;
        for (int i = 0; i < 8; i++) got[i] = 32'h0;
        bif.re_s = 1'b1;
        for (int c = 0; c < max_cyc && nack < n; c++) begin
            tick();
            if (bif.ack_o_s) begin
                if (prev) consec = 1'b1;
                if (nack < 8) got[nack] = bif.dat_out_s;
                nack++;
                if (nack == n) bif.re_s = 1'b0;
            end
            prev = bif.ack_o_s;
        end
        bif.re_s = 1'b0;
        repeat (3) begin
            tick();
            if (bif.ack_o_s) nack++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bif.we_m = 1'b1;
        bif.dat_in_m = 32'h1234_5678;
        repeat (2) tick();
        checks++; if (bif.free_bd !== 3'd4) begin failures++; $display("FAIL reset_free got=%0d exp=4", bif.free_bd); end
        checks++; if (bif.ack_o_s !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bif.ack_o_s); end
        checks++; if (bif.wr_err !== 1'b0) begin failures++; $display("FAIL reset_wr_err got=%b exp=0", bif.wr_err); end
        checks++; if (bif.new_bw !== 1'b0) begin failures++; $display("FAIL reset_new_bw got=%b exp=0", bif.new_bw); end
        checks++; if (bif.dat_out_s !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h exp=0", bif.dat_out_s); end
        bif.we_m = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int nack;
        bit consec;
        logic [31:0] got [8];
        bif.re_s = 1'b1;
        bif.we_m = 1'b1;
        bif.dat_in_m = 32'h1000_0000;
        tick();
        checks++; if (bif.new_bw !== 1'b0) begin failures++; $display("FAIL single_half_new_bw got=%b exp=0", bif.new_bw); end
        checks++; if (bif.ack_o_s !== 1'b0) begin failures++; $display("FAIL single_half_ack got=%b exp=0", bif.ack_o_s); end
        bif.dat_in_m = 32'h0000_0200;
        tick();
        bif.we_m = 1'b0;
        checks++; if (bif.new_bw !== 1'b1) begin failures++; $display("FAIL single_new_bw got=%b exp=1", bif.new_bw); end
        checks++; if (bif.free_bd !== 3'd3) begin failures++; $display("FAIL single_free got=%0d exp=3", bif.free_bd); end
        read_n(2, 20, nack, consec, got);
        checks++; if (nack !== 2) begin failures++; $display("FAIL single_nack got=%0d exp=2", nack); end
        checks++; if (got[0] !== 32'h1000_0000) begin failures++; $display("FAIL single_w0 got=%h exp=10000000", got[0]); end
        checks++; if (got[1] !== 32'h0000_0200) begin failures++; $display("FAIL single_w1 got=%h exp=00000200", got[1]); end
        checks++; if (consec !== 1'b0) begin failures++; $display("FAIL single_ack_gap got=%b exp=0", consec); end
        pulse_cmp();
        checks++; if (bif.free_bd !== 3'd4) begin failures++; $display("FAIL single_release got=%0d exp=4", bif.free_bd); end
    endtask

    task automatic test_full();
        int nack;
        bit consec;
        logic [31:0] got [8];
        for (int k = 0; k < 8; k++) wr_word(32'h3000_0000 + 32'(k));
        checks++; if (bif.free_bd !== 3'd0) begin failures++; $display("FAIL full_free got=%0d exp=0", bif.free_bd); end
        checks++; if (bif.wr_err !== 1'b0) begin failures++; $display("FAIL full_err_early got=%b exp=0", bif.wr_err); end
        wr_word(32'h0000_DEAD);
        checks++; if (bif.wr_err !== 1'b1) begin failures++; $display("FAIL full_wr_err got=%b exp=1", bif.wr_err); end
        read_n(8, 40, nack, consec, got);
        checks++; if (nack !== 8) begin failures++; $display("FAIL full_nack got=%0d exp=8", nack); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (got[k] !== 32'h3000_0000 + 32'(k)) begin failures++; $display("FAIL full_word%0d got=%h exp=%h", k, got[k], 32'h3000_0000 + 32'(k)); end
        end
        checks++; if (consec !== 1'b0) begin failures++; $display("FAIL full_ack_gap got=%b exp=0", consec); end
        read_n(1, 10, nack, consec, got);
        checks++; if (nack !== 0) begin failures++; $display("FAIL full_dropped_read got=%0d exp=0", nack); end
        for (int k = 0; k < 4; k++) pulse_cmp();
        checks++; if (bif.free_bd !== 3'd4) begin failures++; $display("FAIL full_release got=%0d exp=4", bif.free_bd); end
        pulse_cmp();
        checks++; if (bif.free_bd !== 3'd4) begin failures++; $display("FAIL full_extra_cmp got=%0d exp=4", bif.free_bd); end
        checks++; if (bif.wr_err !== 1'b1) begin failures++; $display("FAIL full_err_sticky got=%b exp=1", bif.wr_err); end
    endtask

    task automatic test_wrap();
        int nack;
        bit consec;
        logic [31:0] got [8];
        logic [31:0] exp_w;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) wr_word(32'hA000_0000 + 32'(r * 16 + k));
            checks++; if (bif.free_bd !== 3'd2) begin failures++; $display("FAIL wrap_r%0d_free2 got=%0d exp=2", r, bif.free_bd); end
            read_n(4, 30, nack, consec, got);
            checks++; if (nack !== 4) begin failures++; $display("FAIL wrap_r%0d_nack got=%0d exp=4", r, nack); end
            for (int k = 0; k < 4; k++) begin
                exp_w = 32'hA000_0000 + 32'(r * 16 + k);
                checks++; if (got[k] !== exp_w) begin failures++; $display("FAIL wrap_r%0d_w%0d got=%h exp=%h", r, k, got[k], exp_w); end
            end
            pulse_cmp();
            pulse_cmp();
            checks++; if (bif.free_bd !== 3'd4) begin failures++; $display("FAIL wrap_r%0d_free4 got=%0d exp=4", r, bif.free_bd); end
        end
    endtask

    task automatic test_half_desc();
        int nack;
        int seen;
        int waited;
        bit consec;
        logic [31:0] got [8];
        wr_word(32'h5555_0000);
        bif.re_s = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (bif.ack_o_s) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL half_no_ack got=%0d exp=0", seen); end
        wr_word(32'h5555_0001);
        waited = 0;
        while (!bif.ack_o_s && waited < 2) begin
            tick();
            waited++;
        end
        checks++; if (bif.ack_o_s !== 1'b1) begin failures++; $display("FAIL half_ack_late got=%b exp=1", bif.ack_o_s); end
        checks++; if (bif.dat_out_s !== 32'h5555_0000) begin failures++; $display("FAIL half_w0 got=%h exp=55550000", bif.dat_out_s); end
        read_n(1, 10, nack, consec, got);
        checks++; if (got[0] !== 32'h5555_0001) begin failures++; $display("FAIL half_w1 got=%h exp=55550001", got[0]); end
        pulse_cmp();
        checks++; if (bif.free_bd !== 3'd4) begin failures++; $display("FAIL half_free got=%0d exp=4", bif.free_bd); end
    endtask

    task automatic test_cmp_commit_clr();
        int nack;
        bit consec;
        logic [31:0] got [8];
        for (int k = 0; k < 4; k++) wr_word(32'h7000_0000 + 32'(k));
        checks++; if (bif.free_bd !== 3'd2) begin failures++; $display("FAIL sim_pre got=%0d exp=2", bif.free_bd); end
        wr_word(32'h7000_0004);
        bif.we_m = 1'b1;
        bif.dat_in_m = 32'h7000_0005;
        bif.a_cmp = 1'b1;
        tick();
        bif.we_m = 1'b0;
        bif.a_cmp = 1'b0;
        checks++; if (bif.free_bd !== 3'd2) begin failures++; $display("FAIL sim_free got=%0d exp=2", bif.free_bd); end
        checks++; if (bif.new_bw !== 1'b1) begin failures++; $display("FAIL sim_new_bw got=%b exp=1", bif.new_bw); end
        checks++; if (bif.wr_err !== 1'b1) begin failures++; $display("FAIL sim_err_before_clr got=%b exp=1", bif.wr_err); end
        bif.re_s = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bif.re_s = 1'b0;
        checks++; if (bif.ack_o_s !== 1'b0) begin failures++; $display("FAIL clr_ack got=%b exp=0", bif.ack_o_s); end
        checks++; if (bif.free_bd !== 3'd4) begin failures++; $display("FAIL clr_free got=%0d exp=4", bif.free_bd); end
        checks++; if (bif.wr_err !== 1'b0) begin failures++; $display("FAIL clr_wr_err got=%b exp=0", bif.wr_err); end
        checks++; if (bif.dat_out_s !== 32'h0) begin failures++; $display("FAIL clr_dat got=%h exp=0", bif.dat_out_s); end
        read_n(1, 10, nack, consec, got);
        checks++; if (nack !== 0) begin failures++; $display("FAIL clr_empty_read got=%0d exp=0", nack); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        clr = 1'b0;
        bif.we_m = 1'b0;
        bif.dat_in_m = 32'h0;
        bif.re_s = 1'b0;
        bif.a_cmp = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_wrap();
        test_half_desc();
        test_cmp_commit_clr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
